// File: rtl/arbitro_mux2.sv
`default_nettype none
// ============================================================================
//  Module      : arbitro_mux2
//  Description : Two-requester round-robin arbiter and sequencer for the
//                32-bit 2:1 datapath mux. Chooses which source owns the shared
//                path, drives the mux select, acknowledges the granted
//                requester and registers the selected word into a valid/ready
//                output stage. A per-grant burst limit keeps either source
//                from monopolising the mux while the other one waits.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   rising-edge clock
//    reset      in   asynchronous, active-high reset
//    req1       in   source 1 has a word on data1 (held until ack1)
//    data1      in   source 1 word, stable while req1=1
//    req2       in   source 2 has a word on data2 (held until ack2)
//    data2      in   source 2 word, stable while req2=1
//    out_ready  in   downstream accepts data_out this cycle
//    ack1       out  source 1 word taken this cycle (combinational)
//    ack2       out  source 2 word taken this cycle (combinational)
//    sel        out  mux select: 0 = data1, 1 = data2
//    out_valid  out  data_out holds a valid word
//    data_out   out  registered selected word
// ============================================================================
module arbitro_mux2 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4      // legal range 1..15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             req2,
    input  logic [WIDTH-1:0] data2,
    input  logic             out_ready,
    output logic             ack1,
    output logic             ack2,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G1   = 2'd1,
        ST_G2   = 2'd2
    } state_t;

    // Beat count at which the current grant must be offered to the other side.
    localparam logic [3:0] c_last_beat = 4'(MAX_BURST - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_last_grant;   // 0 = source 1, 1 = source 2
    logic [3:0]         r_burst_cnt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_data_out;

    logic               w_space;
    logic               w_ack1;
    logic               w_ack2;
    logic               w_beat;
    logic               w_at_limit;
    logic               w_enter;
    logic [WIDTH-1:0]   w_sel_data;

    // Output register can take a word when empty or being drained this cycle.
    assign w_space    = !r_out_valid || out_ready;
    assign w_ack1     = (r_state == ST_G1) && req1 && w_space;
    assign w_ack2     = (r_state == ST_G2) && req2 && w_space;
    assign w_beat     = w_ack1 || w_ack2;
    assign w_at_limit = (r_burst_cnt == c_last_beat);

    // Data only feeds the output register, never any control signal.
    assign w_sel_data = (r_state == ST_G2) ? data2 : data1;

    // Next-state: grants move directly between sources without an idle bubble.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req1 && req2) begin
                    // Tie: favour the source that was not granted last.
                    w_next_state = r_last_grant ? ST_G1 : ST_G2;
                end else if (req1) begin
                    w_next_state = ST_G1;
                end else if (req2) begin
                    w_next_state = ST_G2;
                end
            end
            ST_G1: begin
                if (!req1) begin
                    w_next_state = req2 ? ST_G2 : ST_IDLE;
                end else if (w_beat && w_at_limit && req2) begin
                    w_next_state = ST_G2;
                end
            end
            ST_G2: begin
                if (!req2) begin
                    w_next_state = req1 ? ST_G1 : ST_IDLE;
                end else if (w_beat && w_at_limit && req1) begin
                    w_next_state = ST_G1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A fresh grant (from IDLE or from the other source) starts a new burst.
    assign w_enter = (w_next_state != r_state) && (w_next_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;           // source 1 wins the first tie
            r_burst_cnt  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_enter) begin
                r_last_grant <= (w_next_state == ST_G2);
                r_burst_cnt  <= 4'd0;
            end else if (w_beat) begin
                // Limit reached with nobody else waiting: keep the grant,
                // but start counting a new burst.
                r_burst_cnt <= w_at_limit ? 4'd0 : r_burst_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else begin
            if (w_beat) begin
                r_out_valid <= 1'b1;
                r_data_out  <= w_sel_data;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign ack1      = w_ack1;
    assign ack2      = w_ack2;
    assign sel       = (r_state == ST_G2);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_mux2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbitro_mux2
//  Description : Self-checking bench for arbitro_mux2. Two instances run side
//                by side (burst limit 4 and burst limit 1), each driven by
//                randomized requester agents and compared every cycle against
//                a behavioural model of the grant/burst/output-stage rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_mux2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        req1_s [2];
    logic        req2_s [2];
    logic        rdy_s  [2];
    logic [31:0] dat1_s [2];
    logic [31:0] dat2_s [2];
    logic        ack1_o [2];
    logic        ack2_o [2];
    logic        sel_o  [2];
    logic        ov_o   [2];
    logic [31:0] dout_o [2];

    int n_cmp = 0;
    int n_bad = 0;

    arbitro_mux2 #(.WIDTH(32), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .req1(req1_s[0]), .data1(dat1_s[0]),
        .req2(req2_s[0]), .data2(dat2_s[0]),
        .out_ready(rdy_s[0]),
        .ack1(ack1_o[0]), .ack2(ack2_o[0]), .sel(sel_o[0]),
        .out_valid(ov_o[0]), .data_out(dout_o[0])
    );

    arbitro_mux2 #(.WIDTH(32), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req1(req1_s[1]), .data1(dat1_s[1]),
        .req2(req2_s[1]), .data2(dat2_s[1]),
        .out_ready(rdy_s[1]),
        .ack1(ack1_o[1]), .ack2(ack2_o[1]), .sel(sel_o[1]),
        .out_valid(ov_o[1]), .data_out(dout_o[1])
    );

    always #5 clk = ~clk;

    // Reference model: owner 0 = nobody, 1 = source 1, 2 = source 2.
    int          maxb    [2];
    int          m_own   [2];
    int          m_last  [2];
    int          m_beats [2];
    bit          m_ov    [2];
    logic [31:0] m_do    [2];
    bit          m_a1    [2];
    bit          m_a2    [2];

    // Stimulus knobs (percent probabilities).
    int          p_raise1, p_raise2, p_cont, p_drop, p_ready;
    bit          use_seq;
    logic [31:0] seq_next [2];

    // Observations and fairness statistics.
    bit          obs_a1  [2];
    bit          obs_sel [2];
    bit          in_fair;
    int          fair_iter, bubbles, bad_runs;
    int          prev_src [2];
    int          run_len  [2];
    bit          run_ok   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic next_word(input int k, output logic [31:0] w);
        if (use_seq) begin
            w = seq_next[k];
            seq_next[k] = seq_next[k] + 32'd1;
        end else begin
            w = $urandom;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = 0; m_last[k] = 2; m_beats[k] = 0;
            m_ov[k] = 1'b0; m_do[k] = '0; m_a1[k] = 1'b0; m_a2[k] = 1'b0;
        end
    endtask

    // Requesters hold req and data until acknowledged; they may also give up.
    task automatic drive_agents();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] w;
            if (m_a1[k]) begin
                next_word(k, w); dat1_s[k] = w; req1_s[k] = rnd(p_cont);
            end else if (req1_s[k]) begin
                if (rnd(p_drop)) req1_s[k] = 1'b0;
            end else if (rnd(p_raise1)) begin
                next_word(k, w); dat1_s[k] = w; req1_s[k] = 1'b1;
            end
            if (m_a2[k]) begin
                next_word(k, w); dat2_s[k] = w; req2_s[k] = rnd(p_cont);
            end else if (req2_s[k]) begin
                if (rnd(p_drop)) req2_s[k] = 1'b0;
            end else if (rnd(p_raise2)) begin
                next_word(k, w); dat2_s[k] = w; req2_s[k] = 1'b1;
            end
            rdy_s[k] = rnd(p_ready);
        end
    endtask

    task automatic fair_stats(input int k);
        int src;
        src = ack1_o[k] ? 1 : (ack2_o[k] ? 2 : 0);
        if (fair_iter >= 2 && src == 0) bubbles++;
        if (src != 0) begin
            if (src == prev_src[k]) begin
                run_len[k]++;
            end else begin
                if (run_ok[k] && run_len[k] != maxb[k]) bad_runs++;
                if (prev_src[k] != 0 && !run_ok[k]) run_ok[k] = 1'b1;
                run_len[k]  = 1;
                prev_src[k] = src;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_agents();
        #1;
        for (int k = 0; k < 2; k++) begin
            bit space, a1, a2, rq, oth;
            int nxt, othid;
            space = !m_ov[k] || rdy_s[k];
            a1 = (m_own[k] == 1) && req1_s[k] && space;
            a2 = (m_own[k] == 2) && req2_s[k] && space;
            check($sformatf("ack1[%0d]", k), 32'(ack1_o[k]), 32'(a1));
            check($sformatf("ack2[%0d]", k), 32'(ack2_o[k]), 32'(a2));
            check($sformatf("sel[%0d]", k),  32'(sel_o[k]),  32'(m_own[k] == 2));
            obs_a1[k]  = ack1_o[k];
            obs_sel[k] = sel_o[k];
            if (in_fair) fair_stats(k);

            nxt = m_own[k];
            if (m_own[k] == 0) begin
                if (req1_s[k] && req2_s[k]) nxt = (m_last[k] == 1) ? 2 : 1;
                else if (req1_s[k])         nxt = 1;
                else if (req2_s[k])         nxt = 2;
            end else begin
                rq    = (m_own[k] == 1) ? req1_s[k] : req2_s[k];
                oth   = (m_own[k] == 1) ? req2_s[k] : req1_s[k];
                othid = 3 - m_own[k];
                if (!rq) begin
                    nxt = oth ? othid : 0;
                end else if (a1 || a2) begin
                    m_beats[k]++;
                    if (m_beats[k] == maxb[k]) begin
                        m_beats[k] = 0;
                        if (oth) nxt = othid;
                    end
                end
            end
            if (nxt != m_own[k] && nxt != 0) begin
                m_beats[k] = 0;
                m_last[k]  = nxt;
            end
            m_own[k] = nxt;

            if (a1 || a2) begin
                m_ov[k] = 1'b1;
                m_do[k] = a1 ? dat1_s[k] : dat2_s[k];
            end else if (rdy_s[k]) begin
                m_ov[k] = 1'b0;
            end
            m_a1[k] = a1;
            m_a2[k] = a2;
        end
        if (in_fair) fair_iter++;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid[%0d]", k), 32'(ov_o[k]), 32'(m_ov[k]));
            check($sformatf("data_out[%0d]", k),  dout_o[k],     m_do[k]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_ack1[%0d]", tag, k), 32'(ack1_o[k]), 32'd0);
            check($sformatf("%s_ack2[%0d]", tag, k), 32'(ack2_o[k]), 32'd0);
            check($sformatf("%s_sel[%0d]", tag, k),  32'(sel_o[k]),  32'd0);
            check($sformatf("%s_ov[%0d]", tag, k),   32'(ov_o[k]),   32'd0);
            check($sformatf("%s_dout[%0d]", tag, k), dout_o[k],      32'd0);
        end
    endtask

    initial begin
        maxb[0] = 4;
        maxb[1] = 1;
        for (int k = 0; k < 2; k++) begin
            req1_s[k] = 1'b0; req2_s[k] = 1'b0; rdy_s[k] = 1'b1;
            dat1_s[k] = '0;   dat2_s[k] = '0;
            prev_src[k] = 0;  run_len[k] = 0;  run_ok[k] = 1'b0;
        end
        p_raise1 = 0; p_raise2 = 0; p_cont = 0; p_drop = 0; p_ready = 100;
        use_seq = 1'b0; in_fair = 1'b0;
        fair_iter = 0; bubbles = 0; bad_runs = 0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Single source: source 1 streams 0x11, 0x12, ... with no stalls.
        use_seq     = 1'b1;
        seq_next[0] = 32'h11;
        seq_next[1] = 32'h11;
        p_raise1 = 100; p_cont = 100;
        repeat (7) cycle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("single_last[%0d]", k), dout_o[k], 32'h16);
            check($sformatf("single_sel[%0d]", k),  32'(sel_o[k]), 32'd0);
        end
        use_seq = 1'b0;

        // Burst fairness: both request continuously.
        p_raise2 = 100;
        in_fair  = 1'b1;
        repeat (40) cycle();
        in_fair  = 1'b0;
        check("fair_bubbles", 32'(bubbles), 32'd0);
        check("fair_runs",    32'(bad_runs), 32'd0);
        check("fair_seen4",   32'(run_ok[0]), 32'd1);
        check("fair_seen1",   32'(run_ok[1]), 32'd1);

        // Reset mid-burst with a valid word held.
        @(negedge clk);
        check("pre_reset_valid", 32'(ov_o[0]), 32'd1);
        #3 reset = 1'b1;
        #1 check_all_zero("midreset");
        model_reset();
        for (int k = 0; k < 2; k++) begin
            req1_s[k] = 1'b1;
            req2_s[k] = 1'b1;
        end
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) cycle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("first_grant_ack1[%0d]", k), 32'(obs_a1[k]),  32'd1);
            check($sformatf("first_grant_sel[%0d]", k),  32'(obs_sel[k]), 32'd0);
        end

        // Backpressure with both sources busy.
        p_ready = 40;
        repeat (80) cycle();

        // Fully random mix with requesters giving up their grant.
        p_raise1 = 50; p_raise2 = 50; p_cont = 60; p_drop = 25; p_ready = 75;
        repeat (300) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbitro_mux2.md
# arbitro_mux2

Two-requester round-robin arbiter and sequencer for the 32-bit 2:1 datapath mux (Mux2). It decides which source (In1 or In2) owns the shared path, drives the mux select, handshakes each requester, and registers the selected word into a valid/ready output stage feeding the downstream datapath. Fairness is bounded by a per-grant burst limit, so neither source can monopolise the mux.

## Interface
- Width, 32, data width of both sources and the output.
- MaxBurst, 4, max consecutive beats for one grant while the other source waits; legal range 1..15.

- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Req1  input  1  source 1 has a word on Data1; held until Ack1.
- Data1  input  Width  source 1 word; stable while Req1=1.
- Req2  input  1  source 2 request.
- Data2  input  Width  source 2 word.
- OutReady  input  1  downstream accepts DataOut this cycle.
- Ack1  output  1  source 1 word taken this cycle (combinational).
- Ack2  output  1  source 2 word taken this cycle (combinational).
- Sel  output  1  mux select: 0 = In1/Data1, 1 = In2/Data2; drives Mux2 Enable.
- OutValid  output  1  DataOut holds a valid word.
- DataOut  output  Width  registered selected word.

## Operation
- States: IDLE, G1, G2 (2-bit register). Sel = (State==G2).
- Space = !OutValid | OutReady. Ack_i = (State==G_i) & Req_i & Space. Beat = Ack1|Ack2.
- On Beat: DataOut <= selected data, OutValid <= 1. Else if OutReady: OutValid <= 0. DataOut holds when not loaded.
- LastGrant (1 bit) records the most recently granted source; updated on every entry into G1/G2.
- BurstCnt (4 bits): cleared on entry to any G state; +1 per Beat.
- IDLE: Req1&Req2 -> grant the source != LastGrant; only Req_i -> G_i; none -> IDLE.
- G_i, evaluated at each edge, in priority order:
  - Req_i=0 (no Ack this cycle): other Req -> G_other, else IDLE.
  - Beat with BurstCnt==MaxBurst-1: other Req -> G_other; else stay G_i, BurstCnt cleared.
  - otherwise stay G_i.
- A requester that drops Req without Ack loses its grant; word is not taken.
- Simultaneous Req rise from IDLE: round-robin tie-break; after reset source 1 wins first.
- Backpressure (OutValid=1, OutReady=0): no Ack, state and BurstCnt hold; grant is not lost while Req_i stays high.

## Timing
- Reset values (immediate, asynchronous): State=IDLE, Sel=0, Ack1=Ack2=0, OutValid=0, DataOut=0, BurstCnt=0, LastGrant=source 2.
- Reset mid-transfer: in-flight word discarded, no Ack issued after reset asserts; requesters re-present.
- Arbitration latency: Req rises in IDLE at cycle N -> G state and Ack at N+1 (if Space) -> OutValid/DataOut at N+2.
- Sustained throughput: 1 word/cycle while a grant holds and OutReady=1.
- Switch G_i -> G_other is direct (no IDLE bubble); other source's Ack possible in the first cycle after the switch.
- Ack_i, Sel and Space-derived signals are combinational from registered state plus Req_i/OutReady; no combinational path from Data to any control output.

## Test plan
- Reset: assert Reset mid-burst with OutValid=1 -> all outputs 0 same cycle, State IDLE; after release, Req1=Req2=1 -> Ack1 first (Sel=0).
- Single source: Req1=1 for 6 words 0x11..0x16, Req2=0, OutReady=1 -> Ack1 from cycle 1, DataOut 0x11..0x16 on cycles 2..7, Sel stays 0, no stall.
- Burst fairness, MaxBurst=4: both requesting continuously -> 4 Ack1, then 4 Ack2, alternating; Sel toggles every 4 beats with no idle cycle.
- Backpressure: OutReady=0 for 3 cycles while G2 holds with OutValid=1 -> Ack2=0, DataOut held (e.g. 0xDEADBEEF), BurstCnt frozen; OutReady=1 resumes with next word.
- Grant drop: Req1 falls while in G1 with Req2=1 -> next cycle G2, Sel=1, Ack2=1; source 1 word not captured.
- MaxBurst=1 both requesting -> Ack1, Ack2, Ack1, ... strictly alternating, DataOut alternates Data1/Data2.
